// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, FSM encoding and oversampling tick constants for the UART receiver
package uart_pkg;
  localparam int DEF_CLK_HZ     = 100_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam logic [3:0] TC_V0  = 4'd7;
  localparam logic [3:0] TC_V1  = 4'd8;
  localparam logic [3:0] TC_V2  = 4'd9;
  localparam logic [3:0] TC_END = 4'd15;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: fractional phase accumulator giving a 1-clock tick at INC/CLK_HZ of the clock rate
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int INC    = DEF_BAUD * DEF_OVERSAMPLE,
  parameter int ACC_W  = 32
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  output logic tick_o
);
  localparam logic [ACC_W-1:0] LIM  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] STEP = ACC_W'(INC);
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             wrap;
  assign acc_nxt = acc + STEP;
  assign wrap    = acc_nxt >= LIM;
  // free-running accumulator; the remainder is kept on wrap so there is no drift
  always_ff @(negedge sys_clk_i or posedge sys_rst_i)
    if (sys_rst_i) begin
      acc    <= '0;
      tick_o <= 1'b0;
    end else begin
      acc    <= wrap ? acc_nxt - LIM : acc_nxt;
      tick_o <= wrap;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, majority vote and a single-entry holding register
module uart_rx import uart_pkg::*; #(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int ACC_W      = 32
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_overrun_o,
  output logic       uart_frame_err_o,
  output logic       uart_busy_o
);
  logic [1:0] sync;
  logic       rx_s;
  logic       tick;
  state_t     state;
  logic [3:0] tc;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic       s0;
  logic       s1;
  logic       vote;
  logic       rd_hit;
  assign rx_s   = sync[1];
  assign vote   = maj3(s0, s1, rx_s);
  assign rd_hit = uart_rd_i & uart_valid_o;
  uart_baud_tick #(
    .CLK_HZ(CLK_HZ),
    .INC   (BAUD * OVERSAMPLE),
    .ACC_W (ACC_W)
  ) u_tick (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .tick_o   (tick)
  );
  // two-flop synchroniser for the asynchronous line, idle high
  always_ff @(negedge sys_clk_i or posedge sys_rst_i)
    if (sys_rst_i) sync <= 2'b11;
    else           sync <= {sync[0], uart_rx_i};
  // frame FSM, tick counter, vote samples and holding register
  always_ff @(negedge sys_clk_i or posedge sys_rst_i)
    if (sys_rst_i) begin
      state            <= IDLE;
      tc               <= '0;
      bit_idx          <= '0;
      sh               <= '0;
      s0               <= 1'b1;
      s1               <= 1'b1;
      uart_dat_o       <= '0;
      uart_valid_o     <= 1'b0;
      uart_overrun_o   <= 1'b0;
      uart_frame_err_o <= 1'b0;
      uart_busy_o      <= 1'b0;
    end else begin
      uart_frame_err_o <= 1'b0;
      if (rd_hit) begin
        uart_valid_o   <= 1'b0;
        uart_overrun_o <= 1'b0;
      end
      if (tick) begin
        tc <= tc + 4'd1;
        if (tc == TC_V0) s0 <= rx_s;
        if (tc == TC_V1) s1 <= rx_s;
      end
      case (state)
        IDLE:
          if (!rx_s) begin
            tc          <= '0;
            state       <= START;
            uart_busy_o <= 1'b1;
          end
        START:
          if (tick) begin
            if (tc == TC_V2 && vote) begin
              state       <= IDLE;
              uart_busy_o <= 1'b0;
            end else if (tc == TC_END) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        DATA:
          if (tick) begin
            if (tc == TC_V2) sh <= {vote, sh[7:1]};
            if (tc == TC_END) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end
          end
        STOP:
          if (tick && tc == TC_V2) begin
            if (vote) begin
              uart_dat_o     <= sh;
              uart_valid_o   <= 1'b1;
              uart_overrun_o <= (uart_valid_o | uart_overrun_o) & ~uart_rd_i;
              state          <= IDLE;
              uart_busy_o    <= 1'b0;
            end else begin
              uart_frame_err_o <= 1'b1;
              state            <= BREAK;
            end
          end
        BREAK:
          if (rx_s) begin
            state       <= IDLE;
            uart_busy_o <= 1'b0;
          end
        default: begin
          state       <= IDLE;
          uart_busy_o <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 115200 baud and a fast 921600 baud instance
module tb_uart_rx;
  localparam int CPB_SLOW = 868;
  localparam int CPB      = 109;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] s_dat, f_dat;
  logic       s_valid, s_ov, s_fe, s_busy;
  logic       f_valid, f_ov, f_fe, f_busy;
  int         n_vec = 0;
  int         n_bad = 0;
  int         fe_cnt = 0;
  int         sfe_cnt = 0;
  int         busy_cnt = 0;
  time        t_v = 0;
  always #5 clk = ~clk;
  uart_rx u_slow (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_rx_i(rx), .uart_rd_i(rd),
    .uart_dat_o(s_dat), .uart_valid_o(s_valid), .uart_overrun_o(s_ov),
    .uart_frame_err_o(s_fe), .uart_busy_o(s_busy)
  );
  uart_rx #(.CLK_HZ(100_000_000), .BAUD(921_600)) u_fast (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_rx_i(rx), .uart_rd_i(rd),
    .uart_dat_o(f_dat), .uart_valid_o(f_valid), .uart_overrun_o(f_ov),
    .uart_frame_err_o(f_fe), .uart_busy_o(f_busy)
  );
  always @(posedge clk) begin
    if (f_fe) fe_cnt++;
    if (s_fe) sfe_cnt++;
    if (f_busy) busy_cnt++;
  end
  always @(posedge s_valid) t_v = $time;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int cpb);
    rx = 1'b0;
    idle(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(cpb);
    end
    rx = stop;
    idle(cpb);
  endtask
  task automatic read;
    rd = 1'b1;
    idle(1);
    rd = 1'b0;
    idle(1);
  endtask
  initial begin
    automatic logic [7:0] lb [4] = '{8'h00, 8'hFF, 8'h5A, 8'hA5};
    automatic int skew [2] = '{106, 111};
    time t0;
    int  lat, fe0, b0, bd;
    idle(3);
    check("rst_dat", f_dat, 8'h00);
    check("rst_valid", f_valid, 1'b0);
    check("rst_ov", f_ov, 1'b0);
    check("rst_fe", f_fe, 1'b0);
    check("rst_busy", f_busy, 1'b0);
    rst = 1'b0;
    idle(5);
    t0 = $time;
    send(8'h55, 1'b1, CPB_SLOW);
    lat = int'((t_v - t0) / 10);
    check("slow_lat", (lat >= 8250 && lat <= 8420), 1'b1);
    check("slow_dat", s_dat, 8'h55);
    check("slow_valid", s_valid, 1'b1);
    check("slow_ov", s_ov, 1'b0);
    check("slow_fe", sfe_cnt, 0);
    read;
    check("slow_rd", s_valid, 1'b0);
    check("slow_busy", s_busy, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(20);
    fe0 = fe_cnt;
    b0  = busy_cnt;
    rx  = 1'b0;
    idle(38);
    rx  = 1'b1;
    idle(300);
    bd  = busy_cnt - b0;
    check("glitch_valid", f_valid, 1'b0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_busy_len", (bd >= 50 && bd <= 80), 1'b1);
    check("glitch_busy", f_busy, 1'b0);
    fe0 = fe_cnt;
    send(8'hA3, 1'b0, CPB);
    idle(2 * CPB);
    check("brk_busy", f_busy, 1'b1);
    check("brk_fe", fe_cnt - fe0, 1);
    check("brk_valid", f_valid, 1'b0);
    rx = 1'b1;
    idle(50);
    check("brk_idle", f_busy, 1'b0);
    send(8'h3C, 1'b1, CPB);
    check("after_brk_dat", f_dat, 8'h3C);
    check("after_brk_valid", f_valid, 1'b1);
    read;
    send(8'h11, 1'b1, CPB);
    send(8'h22, 1'b1, CPB);
    check("b2b_dat", f_dat, 8'h22);
    check("b2b_valid", f_valid, 1'b1);
    check("b2b_ov", f_ov, 1'b1);
    read;
    check("b2b_rd_valid", f_valid, 1'b0);
    check("b2b_rd_ov", f_ov, 1'b0);
    fe0 = fe_cnt;
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1;
    idle(CPB);
    rx = 1'b0;
    idle(CPB);
    check("mid_busy", f_busy, 1'b1);
    rst = 1'b1;
    idle(2);
    check("mid_rst_busy", f_busy, 1'b0);
    check("mid_rst_dat", f_dat, 8'h00);
    check("mid_rst_valid", f_valid, 1'b0);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(CPB);
    check("mid_idle", f_busy, 1'b0);
    send(8'h7E, 1'b1, CPB);
    check("mid_dat", f_dat, 8'h7E);
    check("mid_valid", f_valid, 1'b1);
    check("mid_fe", fe_cnt - fe0, 0);
    read;
    foreach (lb[i]) begin
      send(lb[i], 1'b1, CPB);
      check($sformatf("loop_dat%0d", i), f_dat, lb[i]);
      check($sformatf("loop_valid%0d", i), f_valid, 1'b1);
      check($sformatf("loop_ov%0d", i), f_ov, 1'b0);
      read;
    end
    foreach (skew[i]) begin
      send(8'h5A, 1'b1, skew[i]);
      check($sformatf("skew_dat%0d", skew[i]), f_dat, 8'h5A);
      check($sformatf("skew_valid%0d", skew[i]), f_valid, 1'b1);
      read;
    end
    check("total_fe", fe_cnt - fe0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
